match_sequencer: RTL

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/pong_pkg.sv | 19 +
 rtl/edge_detect.sv | 21 ++
 rtl/match_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match control blocks.
package pong_pkg;

    localparam int unsigned ScoreWidth  = 3;
    localparam int unsigned LevelWidth  = 3;
    localparam int unsigned DefWinScore = 7;
    localparam int unsigned DefMaxLevel = 7;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StServe    = 3'd1,
        StPlay     = 3'd2,
        StPause    = 3'd3,
        StPoint    = 3'd4,
        StLevelUp  = 3'd5,
        StGameOver = 3'd6
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector on an already-synchronised level input.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/match_sequencer.sv
// Match state machine: serve countdown, scoring, level progression, pause and game over.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = DefWinScore,
    parameter int unsigned SERVE_TICKS = 50_000_000,
    parameter int unsigned MAX_LEVEL   = DefMaxLevel
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause_req,
    input  logic                  p1_point,
    input  logic                  p2_point,
    output logic                  game_on,
    output logic                  round_rst,
    output logic                  serve_dir,
    output logic [ScoreWidth-1:0] p1_score,
    output logic [ScoreWidth-1:0] p2_score,
    output logic [LevelWidth-1:0] level,
    output logic                  lvl_up,
    output logic                  win,
    output logic                  winner,
    output logic [2:0]            fsm_state
);

    localparam int unsigned CntWidth = $clog2(SERVE_TICKS);
    localparam logic [CntWidth-1:0]   CntLoad   = CntWidth'(SERVE_TICKS - 1);
    localparam logic [ScoreWidth-1:0] WinScoreV = ScoreWidth'(WIN_SCORE);
    localparam logic [LevelWidth-1:0] MaxLevelV = LevelWidth'(MAX_LEVEL);

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ScoreWidth-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  serve_dir_q, serve_dir_d;
    logic                  winner_q, winner_d;
    logic                  round_rst_q, round_rst_d;
    logic                  lvl_up_q, lvl_up_d;
    logic                  pause_rise;
    logic [ScoreWidth-1:0] scorer_score;

    edge_detect u_pause_edge (
        .clk   (clk),
        .reset (reset),
        .din   (pause_req),
        .rise  (pause_rise)
    );

    // serve_dir points at the loser, so serve_dir=1 means player 1 took the last point.
    assign scorer_score = serve_dir_q ? p1_score_q : p2_score_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        level_d     = level_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        round_rst_d = 1'b0;
        lvl_up_d    = 1'b0;

        case (state_q)
            StIdle, StGameOver: begin
                if (start) begin
                    state_d     = StServe;
                    cnt_d       = CntLoad;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    level_d     = LevelWidth'(1);
                    serve_dir_d = 1'b0;
                    round_rst_d = 1'b1;
                end
            end
            StServe: begin
                if (cnt_q == '0) begin
                    state_d = StPlay;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StPlay: begin
                if (p1_point ^ p2_point) begin
                    state_d     = StPoint;
                    serve_dir_d = p1_point;
                    if (p1_point) begin
                        if (p1_score_q != WinScoreV) p1_score_d = p1_score_q + 1'b1;
                    end else begin
                        if (p2_score_q != WinScoreV) p2_score_d = p2_score_q + 1'b1;
                    end
                end else if (pause_rise) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (pause_rise) state_d = StPlay;
            end
            StPoint: begin
                if (scorer_score == WinScoreV) begin
                    if (level_q < MaxLevelV) begin
                        state_d     = StLevelUp;
                        level_d     = level_q + 1'b1;
                        lvl_up_d    = 1'b1;
                        p1_score_d  = '0;
                        p2_score_d  = '0;
                        round_rst_d = 1'b1;
                    end else begin
                        state_d  = StGameOver;
                        winner_d = ~serve_dir_q;
                    end
                end else begin
                    state_d     = StServe;
                    cnt_d       = CntLoad;
                    round_rst_d = 1'b1;
                end
            end
            StLevelUp: begin
                state_d = StServe;
                cnt_d   = CntLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            level_q     <= LevelWidth'(1);
            serve_dir_q <= 1'b0;
            winner_q    <= 1'b0;
            round_rst_q <= 1'b0;
            lvl_up_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            level_q     <= level_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
            round_rst_q <= round_rst_d;
            lvl_up_q    <= lvl_up_d;
        end
    end

    assign game_on   = (state_q == StPlay);
    assign win       = (state_q == StGameOver);
    assign round_rst = round_rst_q;
    assign serve_dir = serve_dir_q;
    assign p1_score  = p1_score_q;
    assign p2_score  = p2_score_q;
    assign level     = level_q;
    assign lvl_up    = lvl_up_q;
    assign winner    = winner_q;
    assign fsm_state = state_q;

endmodule
